// File: rtl/pulse_stretcher_fsm.sv
// Stretches a one-cycle trigger into a HOLD_CYCLES-wide level, followed by a GUARD_CYCLES lockout.
// Optional feature macro: PULSE_STRETCH_RETRIGGER_EN (x during HOLD reloads the hold count).
module pulse_stretcher_fsm #(
    parameter int HOLD_CYCLES  = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic y,
    output logic busy
);

    localparam int MAX_COUNT = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
    localparam int CW        = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;

    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] ONE        = 1;

    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("pulse_stretcher_fsm: HOLD_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_GUARD = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          y_q, y_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        y_d     = y_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (x) begin
                    state_d = ST_HOLD;
                    count_d = HOLD_LOAD;
                    y_d     = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    count_d = '0;
                    y_d     = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_HOLD: begin
                y_d    = 1'b1;
                busy_d = 1'b1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
                // A retrigger beats the exit, even on the last hold cycle.
                if (x) begin
                    count_d = HOLD_LOAD;
                end else
`endif
                if (count_q != '0) begin
                    count_d = count_q - ONE;
                end else if (GUARD_CYCLES > 0) begin
                    state_d = ST_GUARD;
                    count_d = GUARD_LOAD;
                    y_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    y_d     = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_GUARD: begin
                y_d    = 1'b0;
                busy_d = 1'b1;
                if (count_q != '0) begin
                    count_d = count_q - ONE;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                y_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;

endmodule
